feature_map_collector: RTL
==========================

Name: feature_map_collector

Overview:
Consumer end of the conv2d output stream. Captures the 36 valid-qualified channel pairs (output_data_0/1 + output_valid) of one 6x6 feature map into an internal buffer. Once the map is complete, it drains the buffer as a byte stream under a valid/ready handshake: channel 0 positions 0..35, then channel 1 positions 0..35. Sits between the conv/relu output and the chip output/readout logic, so a full frame can be read out at host pace instead of being lost to per-cycle overwrites.

Parameters:
DATA_W, 8, width of each feature value
NUM_POS, 36, positions per channel per frame (6x6)
CNT_W, 7, width of byte index/counters (must hold 2*NUM_POS)

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
in_valid  input  1  one channel pair presented this cycle
in_data_0  input  DATA_W  channel 0 value
in_data_1  input  DATA_W  channel 1 value
clear  input  1  synchronous frame flush
out_ready  input  1  downstream accepts byte
out_valid  output  1  byte available
out_data  output  DATA_W  byte being offered
out_last  output  1  marks final byte (channel 1, position NUM_POS-1)
frame_done  output  1  one-cycle pulse on final handshake
overflow  output  1  sticky: input dropped while not capturing
capture_count  output  CNT_W  pairs captured in current frame

Behaviour:
- Clock and reset: clk; reset synchronous, active-high. On reset: state=CAPTURE, capture_count=0, read index=0, out_valid=0, out_last=0, out_data=0, frame_done=0, overflow=0. Buffer contents are don't-care.
- States: CAPTURE, DRAIN.
- CAPTURE:
  - in_valid=1 writes in_data_0 to buf0[capture_count] and in_data_1 to buf1[capture_count]; capture_count increments.
  - The write that makes capture_count==NUM_POS moves the state to DRAIN on the next edge.
  - out_valid=0 throughout CAPTURE.
- DRAIN:
  - out_valid=1 from the first DRAIN cycle, i.e. one cycle after the 36th capture edge.
  - Byte index k=0..2*NUM_POS-1. out_data = buf0[k] for k<NUM_POS, else buf1[k-NUM_POS]; it is a combinational read of the index register.
  - Handshake happens when out_valid & out_ready; k then increments.
  - While out_valid=1 and out_ready=0, out_data/out_last are held stable.
  - out_last=1 exactly when k==2*NUM_POS-1.
  - Handshake on the last byte: frame_done pulses high for the following cycle, state returns to CAPTURE, capture_count=0, k=0.
- in_valid during DRAIN: data is dropped and overflow is set (sticky). A new frame is never captured before the drain completes.
- overflow is cleared only by reset or clear.
- clear (lower priority than reset, higher than everything else): state=CAPTURE, capture_count=0, k=0, out_valid=0, overflow=0. in_valid in the same cycle is ignored. No frame_done pulse.
- Reset or clear mid-capture or mid-drain abandons the partial frame; the next in_valid is stored at position 0.
- No arithmetic on data; values pass through bit-exact. Counters never wrap: capture stops at NUM_POS, k stops at 2*NUM_POS-1.
- Throughput: with out_ready held at 1, the drain takes exactly 2*NUM_POS cycles.

Test Plan:
- Basic frame: 36 in_valid pulses with in_data_0=p, in_data_1=p+100 (p=0..35), out_ready=1.
  - Required: out_valid rises one cycle after the 36th capture.
  - Bytes in order are 0..35 then 100..135; out_last only on byte 135; frame_done pulses once; overflow=0.
- Backpressure: same frame, out_ready toggling 1,0,0,1 pattern.
  - Required: out_data stable whenever out_ready=0; all 72 bytes delivered, none duplicated or skipped.
- Overflow: in_valid=1 with data 0xAA during DRAIN.
  - Required: overflow=1 and stays 1 after drain; drained bytes unaffected; next frame captures from position 0.
- Clear mid-drain after 10 handshakes.
  - Required: out_valid=0 next cycle, capture_count=0, overflow=0; a following 36-pair frame drains correctly from byte 0.
- Reset mid-capture after 20 pairs.
  - Required: all outputs at reset values; the next 36 pairs form a complete frame with the first post-reset pair at position 0.
- Back-to-back frames: two frames sent, the second starting the cycle after frame_done.
  - Required: both frames drain intact; capture_count reads 0 the cycle frame_done is high.

Source files
------------

// File: rtl/feature_map_collector.sv
// Collects one 6x6 two-channel feature map, then replays it as a byte stream (ch0 pos 0..N-1, then ch1 pos 0..N-1).
// Latency: out_valid is set on the edge that captures the last pair; the first byte is offered in the following cycle.
// Backpressure: the byte index only advances on out_valid & out_ready. Input that arrives while draining is dropped and flags overflow.
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   in_valid, in_data_0/1       one channel pair per valid cycle
//   clear                       synchronous frame flush (below reset, above everything else)
//   out_valid/out_ready         byte handshake; out_data is the byte, out_last marks the final byte
//   frame_done                  one-cycle pulse after the final handshake
//   overflow                    sticky; set when input is dropped during drain
//   capture_count               pairs captured in the current frame
module feature_map_collector #(
    parameter int DATA_W  = 8,
    parameter int NUM_POS = 36,
    parameter int CNT_W   = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data_0,
    input  logic [DATA_W-1:0] in_data_1,
    input  logic              clear,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              frame_done,
    output logic              overflow,
    output logic [CNT_W-1:0]  capture_count
);

    localparam int IDX_W = $clog2(NUM_POS);
    localparam logic [CNT_W-1:0] LAST_CAP  = CNT_W'(NUM_POS - 1);
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(2 * NUM_POS - 1);
    localparam logic [CNT_W-1:0] POS_CNT   = CNT_W'(NUM_POS);

    typedef enum logic {
        CAPTURE = 1'b0,
        DRAIN   = 1'b1
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   r_k;
    logic               r_out_valid;
    logic               r_frame_done;
    logic               r_overflow;

    logic [DATA_W-1:0]  r_buf0 [NUM_POS];
    logic [DATA_W-1:0]  r_buf1 [NUM_POS];

    logic               w_hs;
    logic               w_capture;
    logic               w_rd_hi;
    logic [IDX_W-1:0]   w_wr_idx;
    logic [IDX_W-1:0]   w_rd_idx;

    assign w_hs      = r_out_valid & out_ready;
    assign w_capture = (r_state == CAPTURE) & in_valid & ~reset & ~clear;
    assign w_wr_idx  = IDX_W'(r_cnt);

    // Bytes 0..N-1 come from channel 0, N..2N-1 from channel 1 at k-N.
    assign w_rd_hi   = (r_k >= POS_CNT);
    assign w_rd_idx  = IDX_W'(w_rd_hi ? (r_k - POS_CNT) : r_k);

    // Gated by out_valid so the byte lane reads zero outside DRAIN (buffer is never reset).
    assign out_data      = r_out_valid ? (w_rd_hi ? r_buf1[w_rd_idx] : r_buf0[w_rd_idx]) : '0;
    assign out_last      = r_out_valid & (r_k == LAST_BYTE);
    assign out_valid     = r_out_valid;
    assign frame_done    = r_frame_done;
    assign overflow      = r_overflow;
    assign capture_count = r_cnt;

    // Storage has no reset; only control state does.
    always_ff @(posedge clk) begin
        if (w_capture) begin
            r_buf0[w_wr_idx] <= in_data_0;
            r_buf1[w_wr_idx] <= in_data_1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= CAPTURE;
            r_cnt        <= '0;
            r_k          <= '0;
            r_out_valid  <= 1'b0;
            r_frame_done <= 1'b0;
            r_overflow   <= 1'b0;
        end else if (clear) begin
            r_state      <= CAPTURE;
            r_cnt        <= '0;
            r_k          <= '0;
            r_out_valid  <= 1'b0;
            r_frame_done <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                CAPTURE: begin
                    if (in_valid) begin
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == LAST_CAP) begin
                            r_state     <= DRAIN;
                            r_out_valid <= 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (in_valid) begin
                        r_overflow <= 1'b1;
                    end
                    if (w_hs) begin
                        if (r_k == LAST_BYTE) begin
                            r_state      <= CAPTURE;
                            r_cnt        <= '0;
                            r_k          <= '0;
                            r_out_valid  <= 1'b0;
                            r_frame_done <= 1'b1;
                        end else begin
                            r_k <= r_k + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= CAPTURE;
                end
            endcase
        end
    end

endmodule
